// File: rtl/floor_request_scheduler.sv
// floor_request_scheduler: synchronizes raw call buttons, tracks accepted calls in a
// pending bitmap and issues them one at a time to the elevator controller, scanning
// round-robin upward from the last issued floor.
// Optional macro DEBOUNCE_EN: adds a per-button 4-bit debounce counter so a press is
// accepted only after DEBOUNCE_CYCLES consecutive synchronized-high cycles.
module floor_request_scheduler #(
   parameter int DEBOUNCE_CYCLES = 4,
   parameter int HOLD_CYCLES     = 2
) (
   input  logic       clock,
   input  logic       reset,
   input  logic [7:0] buttons,
   input  logic [2:0] current_floor,
   input  logic       door,
   input  logic       emergency_stop,
   output logic [2:0] req_floor,
   output logic       req_valid,
   output logic [7:0] pending
);

   typedef enum logic [1:0] {IDLE, SELECT, HOLD} state_t;

   localparam logic [3:0] HOLD_LAST = 4'(HOLD_CYCLES - 1);

   if (DEBOUNCE_CYCLES < 1 || DEBOUNCE_CYCLES > 15) begin : g_bad_debounce
      $error("DEBOUNCE_CYCLES must be within 1..15");
   end
   if (HOLD_CYCLES < 1 || HOLD_CYCLES > 15) begin : g_bad_hold
      $error("HOLD_CYCLES must be within 1..15");
   end

   state_t     state, state_nxt;
   logic [7:0] sync_p0, sync_p1;
   logic [7:0] accept;
   logic [7:0] issued;
   logic [7:0] candidates;
   logic [7:0] service_clr;
   logic [7:0] issue_set;
   logic [7:0] abort_clr;
   logic [2:0] ptr, ptr_nxt;
   logic [2:0] req_floor_nxt;
   logic       req_valid_nxt;
   logic [3:0] hold_cnt, hold_cnt_nxt;
   logic [2:0] pick, idx;
   logic       pick_found;

   // Two-flop synchronizer in front of every raw button
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         sync_p0 <= '0;
         sync_p1 <= '0;
      end else begin
         sync_p0 <= buttons;
         sync_p1 <= sync_p0;
      end
   end

`ifdef DEBOUNCE_EN
   localparam logic [3:0] DB_LAST = 4'(DEBOUNCE_CYCLES - 1);
   localparam logic [3:0] DB_FULL = 4'(DEBOUNCE_CYCLES);

   logic [3:0] db_cnt [8];

   // Count consecutive synchronized-high cycles; saturate after acceptance, clear on any low
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < 8; i++) db_cnt[i] <= '0;
      end else begin
         for (int i = 0; i < 8; i++) begin
            if (!sync_p1[i])
               db_cnt[i] <= '0;
            else if (db_cnt[i] != DB_FULL)
               db_cnt[i] <= db_cnt[i] + 4'd1;
         end
      end
   end

   // Accept exactly once, on the edge where the high run reaches the threshold
   always_comb begin
      accept = '0;
      for (int i = 0; i < 8; i++)
         accept[i] = sync_p1[i] && (db_cnt[i] == DB_LAST);
   end
`else
   logic [7:0] sync_p2;

   // Previous synchronized level for rising-edge detection
   always_ff @(posedge clock or posedge reset) begin
      if (reset) sync_p2 <= '0;
      else       sync_p2 <= sync_p1;
   end

   assign accept = sync_p1 & ~sync_p2;
`endif

   // A car standing at a floor with the door open services that floor
   assign service_clr = door ? (8'b1 << current_floor) : 8'b0;
   assign candidates  = pending & ~issued;

   // Call bookkeeping: servicing wins over a same-edge accept and over a same-edge issue
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         pending <= '0;
         issued  <= '0;
      end else begin
         pending <= (pending | accept) & ~service_clr;
         issued  <= (issued | issue_set) & ~service_clr & ~abort_clr;
      end
   end

   // Round-robin pick: first candidate scanning upward from ptr+1 with wrap-around
   always_comb begin
      pick       = ptr;
      pick_found = 1'b0;
      idx        = ptr;
      for (int k = 1; k <= 8; k++) begin
         idx = ptr + 3'(k);
         if (!pick_found && candidates[idx]) begin
            pick       = idx;
            pick_found = 1'b1;
         end
      end
   end

   // Issue FSM next-state and registered-output next values
   always_comb begin
      state_nxt     = state;
      req_floor_nxt = req_floor;
      req_valid_nxt = req_valid;
      ptr_nxt       = ptr;
      hold_cnt_nxt  = hold_cnt;
      issue_set     = '0;
      abort_clr     = '0;
      case (state)
         IDLE: begin
            if (candidates != 8'b0 && !emergency_stop)
               state_nxt = SELECT;
         end
         SELECT: begin
            state_nxt = IDLE;
            if (!emergency_stop && pick_found) begin
               state_nxt     = HOLD;
               req_floor_nxt = pick;
               req_valid_nxt = 1'b1;
               ptr_nxt       = pick;
               hold_cnt_nxt  = '0;
               issue_set     = 8'b1 << pick;
            end
         end
         HOLD: begin
            if (emergency_stop) begin
               // Abort: forget the issue so the still-pending floor is offered again
               state_nxt     = IDLE;
               req_valid_nxt = 1'b0;
               abort_clr     = 8'b1 << ptr;
            end else if (hold_cnt == HOLD_LAST) begin
               state_nxt     = IDLE;
               req_valid_nxt = 1'b0;
            end else begin
               hold_cnt_nxt = hold_cnt + 4'd1;
            end
         end
         default: begin
            state_nxt     = IDLE;
            req_valid_nxt = 1'b0;
         end
      endcase
   end

   // FSM state and output registers; reset drops req_valid without waiting for a clock
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state     <= IDLE;
         req_floor <= '0;
         req_valid <= 1'b0;
         ptr       <= 3'd7;
         hold_cnt  <= '0;
      end else begin
         state     <= state_nxt;
         req_floor <= req_floor_nxt;
         req_valid <= req_valid_nxt;
         ptr       <= ptr_nxt;
         hold_cnt  <= hold_cnt_nxt;
      end
   end

endmodule

// File: tb/tb_floor_request_scheduler.sv
// tb_floor_request_scheduler: directed vector tables, hand-written corner sequences and
// randomized traffic, all compared against a behavioural model of the call scheduler.
module tb_floor_request_scheduler;

   localparam int DC = 4;
   localparam int HC = 2;
`ifdef DEBOUNCE_EN
   localparam int ACC_RUN = DC;
`else
   localparam int ACC_RUN = 1;
`endif

   logic       clock = 1'b0;
   logic       reset = 1'b1;
   logic [7:0] buttons = '0;
   logic [2:0] current_floor = '0;
   logic       door = 1'b0;
   logic       emergency_stop = 1'b0;
   logic [2:0] req_floor;
   logic       req_valid;
   logic [7:0] pending;

   int vectors = 0;
   int miscompares = 0;

   floor_request_scheduler #(.DEBOUNCE_CYCLES(DC), .HOLD_CYCLES(HC)) dut (
      .clock          (clock),
      .reset          (reset),
      .buttons        (buttons),
      .current_floor  (current_floor),
      .door           (door),
      .emergency_stop (emergency_stop),
      .req_floor      (req_floor),
      .req_valid      (req_valid),
      .pending        (pending)
   );

   always #5 clock = ~clock;

   // Behavioural model: run lengths of raw presses, call sets, and an issue timeline
   logic [7:0] m_pending, m_issued;
   logic [2:0] m_floor, m_ptr;
   bit         m_armed;
   int         m_hold_left;
   int         m_run [8];
   int         m_run_old [8];

   function automatic void model_reset();
      m_pending   = '0;
      m_issued    = '0;
      m_floor     = '0;
      m_ptr       = 3'd7;
      m_armed     = 1'b0;
      m_hold_left = 0;
      for (int i = 0; i < 8; i++) begin
         m_run[i]     = 0;
         m_run_old[i] = 0;
      end
   endfunction

   function automatic void model_edge();
      logic [7:0] acc, clr, cand, set_m, abort_m;
      int p;
      int pick;
      acc = '0;
      // A press is taken when the raw high run seen two samples ago hits the threshold
      for (int i = 0; i < 8; i++) acc[i] = (m_run_old[i] == ACC_RUN);
      for (int i = 0; i < 8; i++) begin
         m_run_old[i] = m_run[i];
         m_run[i] = buttons[i] ? ((m_run[i] < 1000) ? m_run[i] + 1 : m_run[i]) : 0;
      end
      clr     = door ? (8'(1) << current_floor) : 8'h00;
      cand    = m_pending & ~m_issued;
      set_m   = '0;
      abort_m = '0;
      if (m_armed) begin
         m_armed = 1'b0;
         if (!emergency_stop && cand != 8'h00) begin
            pick = -1;
            for (int k = 1; k <= 8; k++) begin
               p = (int'(m_ptr) + k) % 8;
               if (pick < 0 && cand[p]) pick = p;
            end
            m_floor     = 3'(pick);
            m_ptr       = 3'(pick);
            set_m[pick] = 1'b1;
            m_hold_left = HC;
         end
      end else if (m_hold_left > 0) begin
         if (emergency_stop) begin
            abort_m[m_ptr] = 1'b1;
            m_hold_left    = 0;
         end else begin
            m_hold_left = m_hold_left - 1;
         end
      end else if (cand != 8'h00 && !emergency_stop) begin
         m_armed = 1'b1;
      end
      m_pending = (m_pending | acc) & ~clr;
      m_issued  = (m_issued | set_m) & ~clr & ~abort_m;
   endfunction

   function automatic void chk(string nm, int act, int exp);
      vectors++;
      if (act != exp) begin
         miscompares++;
         $display("FAIL %s: got %0d, wanted %0d (t=%0t)", nm, act, exp, $time);
      end
   endfunction

   // One clock: drive at the falling edge, step the model at the rising edge, compare at the next fall
   task automatic cycle(input logic [7:0] b, input logic [2:0] cf, input logic d, input logic es);
      buttons = b;
      current_floor = cf;
      door = d;
      emergency_stop = es;
      @(posedge clock);
      model_edge();
      @(negedge clock);
      chk("req_valid", int'(req_valid), int'(m_hold_left > 0));
      chk("req_floor", int'(req_floor), int'(m_floor));
      chk("pending",   int'(pending),   int'(m_pending));
   endtask

   task automatic do_reset();
      reset = 1'b1;
      model_reset();
      @(posedge clock);
      @(negedge clock);
      chk("rst_valid",   int'(req_valid), 0);
      chk("rst_floor",   int'(req_floor), 0);
      chk("rst_pending", int'(pending),   0);
      reset = 1'b0;
   endtask

`ifndef DEBOUNCE_EN
   typedef struct {
      logic       rst;
      logic [7:0] b;
      logic [2:0] cf;
      logic       d;
      logic       es;
      logic [7:0] e_pend;
      logic       e_valid;
      logic [2:0] e_floor;
   } vec_t;

   vec_t tbl[$];

   function automatic void add(logic rst, logic [7:0] b, logic [2:0] cf, logic d, logic es,
                               logic [7:0] ep, logic ev, logic [2:0] ef);
      vec_t v;
      v.rst = rst; v.b = b; v.cf = cf; v.d = d; v.es = es;
      v.e_pend = ep; v.e_valid = ev; v.e_floor = ef;
      tbl.push_back(v);
   endfunction
`endif

   initial begin
      #300000;
      $display("FAIL watchdog: simulation did not finish, got timeout, wanted $finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int n;
      logic [7:0] rb;
      model_reset();
      do_reset();

`ifndef DEBOUNCE_EN
      // Single press of floor 6 held 10 samples, then the car services floor 6
      add(1, 8'h40, 0, 0, 0, 8'h00, 0, 0);
      add(0, 8'h40, 0, 0, 0, 8'h00, 0, 0);
      add(0, 8'h40, 0, 0, 0, 8'h40, 0, 0);
      add(0, 8'h40, 0, 0, 0, 8'h40, 0, 0);
      add(0, 8'h40, 0, 0, 0, 8'h40, 1, 6);
      add(0, 8'h40, 0, 0, 0, 8'h40, 1, 6);
      add(0, 8'h40, 0, 0, 0, 8'h40, 0, 6);
      add(0, 8'h40, 0, 0, 0, 8'h40, 0, 6);
      add(0, 8'h40, 0, 0, 0, 8'h40, 0, 6);
      add(0, 8'h40, 0, 0, 0, 8'h40, 0, 6);
      add(0, 8'h00, 0, 0, 0, 8'h40, 0, 6);
      add(0, 8'h00, 6, 1, 0, 8'h00, 0, 6);
      // Floors 1 and 7 together from ptr=7: floor 1 first, then floor 7
      add(1, 8'h82, 0, 0, 0, 8'h00, 0, 0);
      add(0, 8'h82, 0, 0, 0, 8'h00, 0, 0);
      add(0, 8'h00, 0, 0, 0, 8'h82, 0, 0);
      add(0, 8'h00, 0, 0, 0, 8'h82, 0, 0);
      add(0, 8'h00, 0, 0, 0, 8'h82, 1, 1);
      add(0, 8'h00, 0, 0, 0, 8'h82, 1, 1);
      add(0, 8'h00, 0, 0, 0, 8'h82, 0, 1);
      add(0, 8'h00, 0, 0, 0, 8'h82, 0, 1);
      add(0, 8'h00, 0, 0, 0, 8'h82, 1, 7);
      add(0, 8'h00, 0, 0, 0, 8'h82, 1, 7);
      add(0, 8'h00, 0, 0, 0, 8'h82, 0, 7);
      add(0, 8'h00, 0, 0, 0, 8'h82, 0, 7);
      add(0, 8'h00, 0, 0, 0, 8'h82, 0, 7);

      for (int i = 0; i < tbl.size(); i++) begin
         if (tbl[i].rst) do_reset();
         cycle(tbl[i].b, tbl[i].cf, tbl[i].d, tbl[i].es);
         chk("tbl_pending", int'(pending),   int'(tbl[i].e_pend));
         chk("tbl_valid",   int'(req_valid), int'(tbl[i].e_valid));
         chk("tbl_floor",   int'(req_floor), int'(tbl[i].e_floor));
      end
`else
      // Two 3-cycle pulses with a gap never reach the debounce threshold; 4 cycles does
      do_reset();
      repeat (3) cycle(8'h08, 0, 0, 0);
      cycle(8'h00, 0, 0, 0);
      repeat (3) cycle(8'h08, 0, 0, 0);
      repeat (4) cycle(8'h00, 0, 0, 0);
      chk("db_short_pulses", int'(pending), 0);
      repeat (4) cycle(8'h08, 0, 0, 0);
      repeat (3) cycle(8'h00, 0, 0, 0);
      chk("db_long_press", int'(pending), 8'h08);
`endif

      // Service with the door open clears pending and discards a coincident press of that floor
      do_reset();
      repeat (6) cycle(8'h20, 0, 0, 0);
      chk("press5", int'(pending), 8'h20);
      repeat (2) cycle(8'h00, 0, 0, 0);
      cycle(8'h20, 0, 0, 0);
      cycle(8'h00, 0, 0, 0);
      cycle(8'h00, 5, 1, 0);
      chk("service_clear", int'(pending), 0);
      repeat (3) cycle(8'h00, 0, 0, 0);
      chk("press_discarded", int'(pending), 0);

      // Emergency stop during HOLD of floor 4 aborts, keeps the call, and reissues it later
      do_reset();
      n = 0;
      while (pending == 8'h00 && n < 20) begin cycle(8'h10, 0, 0, 0); n++; end
      chk("press4", int'(pending), 8'h10);
      n = 0;
      while (!req_valid && n < 20) begin cycle(8'h00, 0, 0, 0); n++; end
      chk("hold4_valid", int'(req_valid), 1);
      chk("hold4_floor", int'(req_floor), 4);
      cycle(8'h00, 0, 0, 1);
      chk("estop_drop", int'(req_valid), 0);
      chk("estop_keep", int'(pending), 8'h10);
      repeat (3) cycle(8'h00, 0, 0, 1);
      chk("estop_idle", int'(req_valid), 0);
      n = 0;
      while (!req_valid && n < 20) begin cycle(8'h00, 0, 0, 0); n++; end
      chk("reissue_valid", int'(req_valid), 1);
      chk("reissue_floor", int'(req_floor), 4);

      // Reset mid-HOLD acts immediately, between clock edges
      #2 reset = 1'b1;
      #1;
      chk("async_valid",   int'(req_valid), 0);
      chk("async_pending", int'(pending),   0);
      model_reset();
      // A press held through reset is still scheduled after release
      buttons = 8'h08;
      do_reset();
      n = 0;
      while (pending == 8'h00 && n < 20) begin cycle(8'h08, 0, 0, 0); n++; end
      chk("held_across_reset", int'(pending), 8'h08);
      n = 0;
      while (!req_valid && n < 20) begin cycle(8'h08, 0, 0, 0); n++; end
      chk("held_issue_floor", int'(req_floor), 3);
      chk("held_issue_valid", int'(req_valid), 1);

      // Random traffic against the model
      do_reset();
      rb = '0;
      for (int t = 0; t < 1200; t++) begin
         if ($urandom_range(0, 3) == 0) rb = 8'($urandom) & 8'($urandom) & 8'($urandom);
         cycle(rb, 3'($urandom_range(0, 7)), ($urandom_range(0, 5) == 0),
               ($urandom_range(0, 19) == 0));
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
